// File: rtl/cpu_sysctl_pkg.sv
// Shared types and default constants for the CPU system controller.
package cpu_sysctl_pkg;

    // Reset sequencer states: CPU held in reset, or CPU running.
    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam logic [15:0] DEFAULT_IRQ_ACK_ADDR = 16'h1800;
    localparam logic [15:0] DEFAULT_WDOG_ADDR    = 16'h2400;
    localparam logic [15:0] DEFAULT_DEC_MASK     = 16'hFC00;

    // Partial address decode: only the bits selected by mask take part,
    // so every combination of the masked-off bits is a mirror.
    function automatic logic addr_match(input logic [15:0] a,
                                        input logic [15:0] target,
                                        input logic [15:0] mask);
        return (a & mask) == (target & mask);
    endfunction

endpackage

// File: rtl/cpu_phase_gen.sv
// Free-running phase counter producing the CPU phi0 clock and the
// end-of-cycle strobe used to qualify bus decodes.
module cpu_phase_gen #(
    parameter int PHI_DIV = 4
) (
    input  logic eclk,
    input  logic reset_n,
    output logic phi0,
    output logic phi_end
);

    localparam int CNT_W = (PHI_DIV > 2) ? $clog2(PHI_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PHI_DIV - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(PHI_DIV / 2);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // Next phase value, wrapping after the last eclk of a phi0 cycle.
    always_comb begin
        count_next = count + CNT_W'(1);
        if (count == LAST) begin
            count_next = '0;
        end
    end

    // Outputs are registered from the next count so they always match it.
    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            count   <= '0;
            phi0    <= 1'b1;
            phi_end <= 1'b0;
        end else begin
            count   <= count_next;
            phi0    <= (count_next < HALF);
            phi_end <= (count_next == LAST);
        end
    end

endmodule

// File: rtl/cpu_sysctl.sv
// CPU system controller: phi0 generation, CPU reset sequencing,
// IRQ pending latch with write-acknowledge, and an IRQ-tick watchdog.
module cpu_sysctl
    import cpu_sysctl_pkg::*;
#(
    parameter int          PHI_DIV      = 4,
    parameter int          RESET_HOLD   = 16,
    parameter logic [15:0] IRQ_ACK_ADDR = DEFAULT_IRQ_ACK_ADDR,
    parameter logic [15:0] WDOG_ADDR    = DEFAULT_WDOG_ADDR,
    parameter logic [15:0] DEC_MASK     = DEFAULT_DEC_MASK,
    parameter int          WDOG_LIMIT   = 8
) (
    input  logic        eclk,
    input  logic        reset_n,
    input  logic        irq_tick,
    input  logic [15:0] cpu_a,
    input  logic        cpu_rw_n,
    output logic        phi0,
    output logic        phi_end,
    output logic        cpu_reset_n,
    output logic        cpu_irq,
    output logic        wdog_fired
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    localparam logic [7:0] WDOG_LIMIT_8 = 8'(WDOG_LIMIT);
    localparam bit WDOG_EN = (WDOG_LIMIT != 0);

    seq_state_t        state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        wdog_cnt;
    logic              ack_hit;
    logic              kick_hit;
    logic              wdog_expire;

    cpu_phase_gen #(
        .PHI_DIV (PHI_DIV)
    ) u_phase_gen (
        .eclk    (eclk),
        .reset_n (reset_n),
        .phi0    (phi0),
        .phi_end (phi_end)
    );

    // Writes only decode on the last eclk of a phi0 cycle, so each bus
    // cycle produces at most one hit per address.
    assign ack_hit  = phi_end & ~cpu_rw_n & addr_match(cpu_a, IRQ_ACK_ADDR, DEC_MASK);
    assign kick_hit = phi_end & ~cpu_rw_n & addr_match(cpu_a, WDOG_ADDR, DEC_MASK);

    // A tick that brings the count to the limit fires, unless a kick lands
    // in the same eclk or a fire is already being acted on.
    assign wdog_expire = WDOG_EN && (state == RUN) && !wdog_fired && irq_tick &&
                         !kick_hit && ((wdog_cnt + 8'd1) == WDOG_LIMIT_8);

    // Reset sequencer: count phi_end strobes in HOLD, drop back on a fire.
    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            cpu_reset_n <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (phi_end) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state       <= RUN;
                            hold_cnt    <= '0;
                            cpu_reset_n <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (wdog_fired) begin
                        state       <= HOLD;
                        hold_cnt    <= '0;
                        cpu_reset_n <= 1'b0;
                    end
                end
                default: begin
                    state       <= HOLD;
                    hold_cnt    <= '0;
                    cpu_reset_n <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog: ticks count up in RUN, kicks clear, reaching the limit fires once.
    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            wdog_cnt   <= 8'd0;
            wdog_fired <= 1'b0;
        end else begin
            wdog_fired <= wdog_expire;
            if ((state != RUN) || wdog_fired || kick_hit || wdog_expire) begin
                wdog_cnt <= 8'd0;
            end else if (irq_tick) begin
                wdog_cnt <= wdog_cnt + 8'd1;
            end
        end
    end

    // IRQ pending latch: tick sets (and beats a same-cycle ack), ack clears.
    always_ff @(posedge eclk) begin
        if (!reset_n) begin
            cpu_irq <= 1'b0;
        end else if ((state != RUN) || wdog_fired) begin
            cpu_irq <= 1'b0;
        end else if (irq_tick) begin
            cpu_irq <= 1'b1;
        end else if (ack_hit) begin
            cpu_irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_sysctl.sv
// Scoreboard bench for cpu_sysctl: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model of the controller.
module tb_cpu_sysctl;

    localparam int          PHI   = 4;
    localparam int          HOLDN = 16;
    localparam int          LIMIT = 8;
    localparam logic [15:0] ACK   = 16'h1800;
    localparam logic [15:0] KICK  = 16'h2400;
    localparam logic [15:0] MASK  = 16'hFC00;

    logic        eclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq_tick = 1'b0;
    logic [15:0] cpu_a = 16'h0000;
    logic        cpu_rw_n = 1'b1;
    logic        phi0;
    logic        phi_end;
    logic        cpu_reset_n;
    logic        cpu_irq;
    logic        wdog_fired;

    int checks = 0;
    int errors = 0;
    int fired_seen = 0;

    // Model: time since reset, run flag, strobes seen in hold, irq, ticks since kick
    int m_t = 0;
    bit m_run = 1'b0;
    int m_hold = 0;
    bit m_irq = 1'b0;
    int m_ticks = 0;
    bit m_fired = 1'b0;

    logic [4:0] exp_q[$];
    logic [4:0] mon_exp;
    logic [4:0] mon_act;

    cpu_sysctl #(
        .PHI_DIV      (PHI),
        .RESET_HOLD   (HOLDN),
        .IRQ_ACK_ADDR (ACK),
        .WDOG_ADDR    (KICK),
        .DEC_MASK     (MASK),
        .WDOG_LIMIT   (LIMIT)
    ) dut (
        .eclk        (eclk),
        .reset_n     (reset_n),
        .irq_tick    (irq_tick),
        .cpu_a       (cpu_a),
        .cpu_rw_n    (cpu_rw_n),
        .phi0        (phi0),
        .phi_end     (phi_end),
        .cpu_reset_n (cpu_reset_n),
        .cpu_irq     (cpu_irq),
        .wdog_fired  (wdog_fired)
    );

    always #5 eclk = ~eclk;

    // Advance the model by one eclk with the given inputs and queue the
    // outputs expected right after that edge.
    task automatic model_step(input bit tick, input logic [15:0] a, input bit rw_n, input bit rst_n);
        bit strobe;
        bit ack;
        bit kick;
        if (!rst_n) begin
            m_t = 0; m_run = 0; m_hold = 0; m_irq = 0; m_ticks = 0; m_fired = 0;
        end else begin
            strobe = ((m_t % PHI) == PHI - 1);
            ack    = strobe && !rw_n && ((a & MASK) == (ACK & MASK));
            kick   = strobe && !rw_n && ((a & MASK) == (KICK & MASK));
            if (!m_run) begin
                m_irq = 0; m_ticks = 0; m_fired = 0;
                if (strobe) begin
                    m_hold++;
                    if (m_hold == HOLDN) begin
                        m_run = 1; m_hold = 0;
                    end
                end
            end else if (m_fired) begin
                m_run = 0; m_hold = 0; m_irq = 0; m_ticks = 0; m_fired = 0;
            end else begin
                if (tick) m_irq = 1;
                else if (ack) m_irq = 0;
                if (kick) m_ticks = 0;
                else if (tick) begin
                    m_ticks++;
                    if (LIMIT != 0 && m_ticks == LIMIT) begin
                        m_fired = 1; m_ticks = 0;
                    end
                end
            end
            m_t++;
        end
        exp_q.push_back({((m_t % PHI) < PHI / 2), ((m_t % PHI) == PHI - 1), m_run, m_irq, m_fired});
    endtask

    // Drive one eclk worth of inputs shortly after the active edge.
    task automatic applyStimulus(input bit tick, input logic [15:0] a, input bit rw_n, input bit rst_n);
        @(posedge eclk);
        #2;
        if (wdog_fired === 1'b1) fired_seen++;
        irq_tick = tick;
        cpu_a    = a;
        cpu_rw_n = rw_n;
        reset_n  = rst_n;
        model_step(tick, a, rw_n, rst_n);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
    endtask

    // Idle until the next stimulus is sampled in phase p of the phi0 cycle.
    task automatic wait_phase(input int p);
        for (int i = 0; i < PHI && (m_t % PHI) != p; i++) idle(1);
    endtask

    // Count eclks until cpu_reset_n rises, bounded.
    task automatic measure_rise(input string name, input int expected);
        int n;
        n = 0;
        do begin
            idle(1);
            n++;
        end while (cpu_reset_n !== 1'b1 && n < 200);
        checkOutput(name, n, expected);
    endtask

    task automatic release_and_check(input string name);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput({name, "_reset_outputs"}, {phi0, phi_end, cpu_reset_n, cpu_irq, wdog_fired}, 5'b10000);
        measure_rise({name, "_release_delay"}, 64);
    endtask

    // Monitor: compare every post-edge output set against the scoreboard.
    always @(posedge eclk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {phi0, phi_end, cpu_reset_n, cpu_irq, wdog_fired};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("[TB] FAIL scoreboard: got %b expected %b (phi0,phi_end,cpu_reset_n,cpu_irq,wdog_fired) at %0t",
                         mon_act, mon_exp, $time);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        $display("[TB] starting cpu_sysctl bench");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        release_and_check("power_on");

        // IRQ set, read does not ack, mirror write acks, tick beats ack
        ticks(1);
        idle(1);
        checkOutput("irq_set", cpu_irq, 1'b1);
        wait_phase(PHI - 1);
        applyStimulus(1'b0, 16'h1800, 1'b1, 1'b1);
        idle(1);
        checkOutput("irq_read_keeps", cpu_irq, 1'b1);
        wait_phase(0);
        applyStimulus(1'b0, 16'h1800, 1'b0, 1'b1);
        idle(1);
        checkOutput("irq_ack_needs_strobe", cpu_irq, 1'b1);
        wait_phase(PHI - 1);
        applyStimulus(1'b0, 16'h1A55, 1'b0, 1'b1);
        idle(1);
        checkOutput("irq_ack_mirror", cpu_irq, 1'b0);
        wait_phase(PHI - 1);
        applyStimulus(1'b1, 16'h1800, 1'b0, 1'b1);
        idle(1);
        checkOutput("irq_tick_wins", cpu_irq, 1'b1);
        wait_phase(PHI - 1);
        applyStimulus(1'b0, 16'h2400, 1'b0, 1'b1);

        // Watchdog fires after LIMIT ticks; the 8th tick is phase-aligned so
        // the re-hold spans exactly 16 phi0 cycles
        fired_seen = 0;
        ticks(LIMIT - 1);
        wait_phase(2);
        ticks(1);
        idle(1);
        checkOutput("wdog_fire", wdog_fired, 1'b1);
        idle(1);
        checkOutput("hold_after_fire", cpu_reset_n, 1'b0);
        checkOutput("fire_one_cycle", wdog_fired, 1'b0);
        measure_rise("rehold_delay", 64);
        checkOutput("fire_count", fired_seen, 1);

        // Kick between two runs of seven ticks prevents a fire
        fired_seen = 0;
        ticks(LIMIT - 1);
        wait_phase(PHI - 1);
        applyStimulus(1'b0, 16'h2400, 1'b0, 1'b1);
        ticks(LIMIT - 1);
        idle(3);
        checkOutput("no_fire_after_kick", fired_seen, 0);
        checkOutput("still_running", cpu_reset_n, 1'b1);

        // Mid-run reset with irq pending and watchdog count at five
        wait_phase(PHI - 1);
        applyStimulus(1'b0, 16'h2400, 1'b0, 1'b1);
        ticks(5);
        idle(1);
        checkOutput("irq_before_reset", cpu_irq, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        release_and_check("mid_run");
        fired_seen = 0;
        ticks(LIMIT - 1);
        idle(2);
        checkOutput("wdog_restart", fired_seen, 0);
        ticks(1);
        idle(2);
        checkOutput("wdog_restart_fire", fired_seen, 1);
        idle(70);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          tick;
            bit          rst_n;
            bit          rw_n;
            logic [15:0] a;
            logic [15:0] r16;
            r16   = 16'($urandom);
            tick  = !m_fired && ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            rw_n  = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: a = ACK | (r16 & ~MASK);
                1: a = KICK | (r16 & ~MASK);
                2: a = r16;
                default: a = ACK ^ (16'h0400 << $urandom_range(0, 5));
            endcase
            applyStimulus(tick, a, rw_n, rst_n);
        end
        idle(1);
        @(posedge eclk);
        #3;
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
